// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: return-tag owner
// encoding, byte-enable width and the default fetch-starvation bound.
package riscv_mem_pkg;

  localparam int BE_W             = 4;
  localparam int DEF_MAX_D_STREAK = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the SRAM pins seen by the arbiter.
// The arbiter uses the slave view; the core/SRAM side uses the master view.
interface mem_port_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int AWIDTH = 12
);

  // fetch port
  logic              I_REQ;
  logic [31:0]       I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;
  // data port
  logic              D_REQ;
  logic              D_WE;
  logic [BE_W-1:0]   D_BE;
  logic [31:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;
  // SRAM pins
  logic              M_CSN;
  logic              M_WEN;
  logic [BE_W-1:0]   M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );

endinterface

// File: rtl/mem_arb_streak_cnt.sv
// Counts consecutive data grants taken while a fetch is waiting and flags
// when the fetch must be given the next slot.
module mem_arb_streak_cnt #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_fetch
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_D_STREAK);

  logic [3:0] streak;

  // Streak advances on each data grant that overtook a pending fetch;
  // it restarts whenever the fetch is served or stops asking.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak <= '0;
    end else if (!i_req || i_gnt) begin
      streak <= '0;
    end else if (d_gnt && streak != MAX_CNT) begin
      streak <= streak + 4'd1;
    end
  end

  assign force_fetch = (streak == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the fetch and data ports. Data wins by
// default; a bounded streak forces a fetch through. Granted reads are tagged
// so the returning word is steered to its owner one cycle later.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AWIDTH       = 12,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  logic   i_gnt;
  logic   d_gnt;
  logic   force_fetch;
  owner_e tag;

  mem_arb_streak_cnt #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .CLK         (CLK),
    .RST         (RST),
    .i_req       (bus.I_REQ),
    .i_gnt       (i_gnt),
    .d_gnt       (d_gnt),
    .force_fetch (force_fetch)
  );

  // Grant selection: data first unless the fetch has waited its full streak.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves a value held, which would infer a latch.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RST) begin
      if (bus.D_REQ && !(bus.I_REQ && force_fetch)) begin
        d_gnt = 1'b1;
      end else if (bus.I_REQ) begin
        i_gnt = 1'b1;
      end
    end
  end

  // SRAM drive: idle pins unless a port holds the grant this cycle.
  always_comb begin
    bus.M_CSN  = 1'b1;
    bus.M_WEN  = 1'b1;
    bus.M_BE   = '0;
    bus.M_ADDR = '0;
    bus.M_DI   = '0;
    if (d_gnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = bus.D_ADDR[AWIDTH+1:2];
      if (bus.D_WE) begin
        bus.M_WEN = 1'b0;
        bus.M_BE  = bus.D_BE;
        bus.M_DI  = bus.D_WDATA;
      end
    end else if (i_gnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = bus.I_ADDR[AWIDTH+1:2];
    end
  end

  // Return tag: remembers who owns the word the SRAM presents next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag <= OWN_NONE;
    end else if (d_gnt && !bus.D_WE) begin
      tag <= OWN_D;
    end else if (i_gnt) begin
      tag <= OWN_I;
    end else begin
      tag <= OWN_NONE;
    end
  end

  assign bus.I_GNT    = i_gnt;
  assign bus.D_GNT    = d_gnt;
  assign bus.I_RVALID = (tag == OWN_I);
  assign bus.D_RVALID = (tag == OWN_D);
  assign bus.I_RDATA  = (tag == OWN_I) ? bus.M_DOUT : 32'd0;
  assign bus.D_RDATA  = (tag == OWN_D) ? bus.M_DOUT : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int AWIDTH = 12;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem [0:(1<<AWIDTH)-1];
  logic [31:0] dout_q = 32'd0;

  mem_port_arbiter_if #(.AWIDTH(AWIDTH)) bus ();

  mem_port_arbiter #(
    .AWIDTH       (AWIDTH),
    .MAX_D_STREAK (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM model: byte-masked write, registered read
  always @(posedge CLK) begin
    if (!bus.M_CSN) begin
      if (!bus.M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bus.M_BE[b]) mem[bus.M_ADDR][8*b +: 8] <= bus.M_DI[8*b +: 8];
      end else begin
        dout_q <= mem[bus.M_ADDR];
      end
    end
  end
  assign bus.M_DOUT = dout_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] da, input logic [31:0] dw);
    bus.I_REQ   = ir;
    bus.I_ADDR  = ia;
    bus.D_REQ   = dr;
    bus.D_WE    = dwe;
    bus.D_BE    = dbe;
    bus.D_ADDR  = da;
    bus.D_WDATA = dw;
  endtask

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  logic [11:0] exp_i12;
  logic [4:0]  exp_i5;

  initial begin
    for (int k = 0; k < (1<<AWIDTH); k++) mem[k] = 32'd0;
    mem[0] = 32'hA5A5_0F0F;
    mem[2] = 32'h0000_0013;

    // reset with both ports requesting
    drive(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      next_cycle(); #1;
      check("rst_i_gnt", 32'(bus.I_GNT), 32'd0);
      check("rst_d_gnt", 32'(bus.D_GNT), 32'd0);
      check("rst_csn", 32'(bus.M_CSN), 32'd1);
      check("rst_i_rvalid", 32'(bus.I_RVALID), 32'd0);
      check("rst_d_rvalid", 32'(bus.D_RVALID), 32'd0);
    end
    check("rst_wen", 32'(bus.M_WEN), 32'd1);
    check("rst_be", 32'(bus.M_BE), 32'd0);
    check("rst_addr", 32'(bus.M_ADDR), 32'd0);
    check("rst_di", bus.M_DI, 32'd0);
    check("rst_i_rdata", bus.I_RDATA, 32'd0);
    check("rst_d_rdata", bus.D_RDATA, 32'd0);

    // release: data granted in the first cycle (read of word 0)
    next_cycle(); RST = 1'b0; #1;
    check("rel_d_gnt", 32'(bus.D_GNT), 32'd1);
    check("rel_i_gnt", 32'(bus.I_GNT), 32'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("rel_d_rvalid", 32'(bus.D_RVALID), 32'd1);
    check("rel_d_rdata", bus.D_RDATA, 32'hA5A5_0F0F);

    // single fetch at 0x8
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("if_gnt", 32'(bus.I_GNT), 32'd1);
    check("if_addr", 32'(bus.M_ADDR), 32'd2);
    check("if_wen", 32'(bus.M_WEN), 32'd1);
    check("if_csn", 32'(bus.M_CSN), 32'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("if_rvalid", 32'(bus.I_RVALID), 32'd1);
    check("if_rdata", bus.I_RDATA, 32'h0000_0013);
    check("if_d_rvalid", 32'(bus.D_RVALID), 32'd0);
    check("if_d_rdata", bus.D_RDATA, 32'd0);

    // partial write then read-back of word 0x40
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF); #1;
    check("wr_gnt", 32'(bus.D_GNT), 32'd1);
    check("wr_wen", 32'(bus.M_WEN), 32'd0);
    check("wr_be", 32'(bus.M_BE), 32'h3);
    check("wr_di", bus.M_DI, 32'hDEAD_BEEF);
    check("wr_addr", 32'(bus.M_ADDR), 32'h40);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0); #1;
    check("wr_no_rvalid", 32'(bus.D_RVALID), 32'd0);
    check("wr_no_i_rvalid", 32'(bus.I_RVALID), 32'd0);
    check("rd_be", 32'(bus.M_BE), 32'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("rd_rvalid", 32'(bus.D_RVALID), 32'd1);
    check("rd_rdata", bus.D_RDATA, 32'h0000_BEEF);
    check("rd_no_i_rvalid", 32'(bus.I_RVALID), 32'd0);

    // starvation bound: D,D,D,D,I,D,D,D,D,I,D,D
    exp_i12 = 12'b0010_0001_0000;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      drive(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0); #1;
      check($sformatf("starve_i_gnt[%0d]", c), 32'(bus.I_GNT), 32'(exp_i12[c]));
      check($sformatf("starve_d_gnt[%0d]", c), 32'(bus.D_GNT), 32'(!exp_i12[c]));
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // wrap-around: 0x4000 aliases word 0
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4000, 32'h0); #1;
    check("wrap_addr", 32'(bus.M_ADDR), 32'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("wrap_rdata", bus.D_RDATA, 32'hA5A5_0F0F);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("base_rdata", bus.D_RDATA, 32'hA5A5_0F0F);

    // reset in the cycle after a granted fetch drops the return
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("rmid_i_gnt", 32'(bus.I_GNT), 32'd1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    RST = 1'b1; #1;
    check("rmid_i_rvalid", 32'(bus.I_RVALID), 32'd0);
    check("rmid_i_rdata", bus.I_RDATA, 32'd0);
    next_cycle(); RST = 1'b0;

    // build a streak of 3, reset, then the streak must start over
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0); #1;
      check($sformatf("pre_d_gnt[%0d]", c), 32'(bus.D_GNT), 32'd1);
    end
    next_cycle(); RST = 1'b1; #1;
    check("rst2_d_gnt", 32'(bus.D_GNT), 32'd0);
    check("rst2_i_gnt", 32'(bus.I_GNT), 32'd0);
    next_cycle(); RST = 1'b0;
    exp_i5 = 5'b10000;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      #1;
      check($sformatf("post_i_gnt[%0d]", c), 32'(bus.I_GNT), 32'(exp_i5[c]));
      check($sformatf("post_d_gnt[%0d]", c), 32'(bus.D_GNT), 32'(!exp_i5[c]));
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and data-access port, so a unified memory can replace the split I/D memories. Sits between the core top and the SRAM model: core-facing request/grant/return handshakes on two ports, SRAM-facing CSN/WEN/BE/ADDR/DI/DOUT. Data requests win by default, and a bounded-streak counter guarantees fetch forward progress. The arbiter also tags each granted read and routes the returned data to its owner one cycle later.

## Interface
Parameters:
- AWIDTH, 12, SRAM word-address width; M_ADDR = request byte address [AWIDTH+1:2]
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (range 1..15)

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- I_REQ  in  1  fetch request (read only)
- I_ADDR  in  32  fetch byte address
- I_GNT  out  1  fetch accepted this cycle
- I_RVALID  out  1  I_RDATA valid this cycle
- I_RDATA  out  32  fetched word
- D_REQ  in  1  data request
- D_WE  in  1  1 = write, 0 = read
- D_BE  in  4  byte enables (write only)
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  write data
- D_GNT  out  1  data request accepted this cycle
- D_RVALID  out  1  D_RDATA valid this cycle (reads only)
- D_RDATA  out  32  read word
- M_CSN  out  1  SRAM chip select, active-low
- M_WEN  out  1  SRAM write enable, active-low
- M_BE  out  4  SRAM byte enables
- M_ADDR  out  AWIDTH  SRAM word address
- M_DI  out  32  SRAM write data
- M_DOUT  in  32  SRAM read data, valid one cycle after access

## Operation
- Grant is combinational on the current request lines. At most one grant per cycle. Requesters hold REQ and all request fields until they see GNT.
- Arbitration:
  - D_REQ only: grant D.
  - I_REQ only: grant I.
  - Both requesting: grant D unless streak == MAX_D_STREAK, in which case grant I.
- Streak counter:
  - Increments when D is granted while I_REQ is high.
  - Clears when I is granted or I_REQ is low.
  - Saturates at MAX_D_STREAK.
- SRAM drive when granted:
  - M_CSN = 0.
  - M_ADDR comes from the granted address.
  - For a D write: M_WEN = 0, M_BE = D_BE, M_DI = D_WDATA.
  - For any read: M_WEN = 1, M_BE = 4'b0000.
- Idle (no grant): M_CSN = 1, M_WEN = 1, M_BE = 0, M_ADDR = 0, M_DI = 0.
- Return tag register, owner ∈ {NONE, I, D}:
  - Set at the clock edge to the owner of a granted read. NONE for writes and idle cycles.
  - Next cycle: the owner's RVALID = 1 and its RDATA = M_DOUT. The non-owner's RDATA = 0.
- Address bits above AWIDTH+1 are ignored: addresses wrap modulo the SRAM size. Address bits [1:0] are ignored.
- While RST is high:
  - I_GNT = D_GNT = 0 and the SRAM is idle.
  - The tag is forced to NONE and the streak counter to 0.
  - A read granted in the cycle before reset asserts is dropped: no RVALID is produced.

## Timing
- Reset values: I_GNT 0, D_GNT 0, I_RVALID 0, D_RVALID 0, I_RDATA 0, D_RDATA 0, M_CSN 1, M_WEN 1, M_BE 0, M_ADDR 0, M_DI 0, internal streak 0, tag NONE.
- Request-to-grant latency is 0 cycles when uncontended.
- Read latency is 1 cycle: GNT in cycle N gives RVALID in cycle N+1.
- Writes complete at the edge ending the grant cycle. A read of the same word granted in the next cycle returns the new data.
- Back-to-back grants to the same or alternating ports are allowed every cycle. RVALID can then be high on consecutive cycles.
- Worst-case fetch wait under continuous D_REQ is MAX_D_STREAK cycles. The grant to I comes in cycle MAX_D_STREAK+1 of contention.

## Structure
- The shared package riscv_mem_pkg holds:
  - owner encoding (OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2);
  - the BE width constant (4);
  - the default MAX_D_STREAK.
- One sub-module, mem_arb_streak_cnt, contains the saturating streak counter and its "force fetch" comparison output.
- The top module contains the grant logic, the SRAM mux and the return-tag register.

## Test plan
- Reset: hold RST high with I_REQ = D_REQ = 1 -> both GNTs stay 0, M_CSN = 1, all RVALIDs stay 0. Deassert RST -> D is granted in the first cycle.
- Single fetch: pre-load word 0x00000013 at I_ADDR 0x8 -> I_GNT = 1, M_ADDR = 2, M_WEN = 1. Next cycle I_RVALID = 1, I_RDATA = 0x00000013, D_RVALID = 0.
- Write then read: D write 0xDEADBEEF, BE 4'b0011 at 0x100 (old word 0), then D read at 0x100 -> D_RVALID next cycle with D_RDATA = 0x0000BEEF. No I_RVALID during the sequence.
- Starvation bound: with MAX_D_STREAK = 4, hold I_REQ and D_REQ high for 12 cycles -> grant order D,D,D,D,I,D,D,D,D,I,D,D.
- Wrap-around: D read at 0x4000 with AWIDTH = 12 -> M_ADDR = 0, returning the same data as address 0x0.
- Reset mid-read: assert RST in the cycle after a granted I read -> I_RVALID = 0 and I_RDATA = 0 immediately. After RST is released the streak counter restarts from 0.
